// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one MemoryBus slave port between NUM_MASTERS requesters.
// Defining MEMARB_PERF_EN adds per-master saturating grant counters on port grant_count.
module memory_bus_arbiter #(
    parameter int unsigned NUM_MASTERS   = 4,
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ID_WIDTH      = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_MASTERS-1:0]               m_msValid,
    input  logic [NUM_MASTERS-1:0]               m_msWrite,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]      m_msID,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_msAddress,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_msData,
    output logic [NUM_MASTERS-1:0]               m_msTaken,
    output logic                                 m_smValid,
    output logic [ID_WIDTH-1:0]                  m_smID,
    output logic [DATA_WIDTH-1:0]                m_smData,
    input  logic [NUM_MASTERS-1:0]               m_smTaken,
    output logic                                 s_msValid,
    output logic                                 s_msWrite,
    output logic [ID_WIDTH-1:0]                  s_msID,
    output logic [ADDRESS_WIDTH-1:0]             s_msAddress,
    output logic [DATA_WIDTH-1:0]                s_msData,
    input  logic                                 s_msTaken,
    input  logic                                 s_smValid,
    input  logic [ID_WIDTH-1:0]                  s_smID,
    input  logic [DATA_WIDTH-1:0]                s_smData,
    output logic                                 s_smTaken
`ifdef MEMARB_PERF_EN
    ,
    output logic [NUM_MASTERS*16-1:0]            grant_count
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_MASTERS);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    logic             free;
    int unsigned      cand;

    assign free = !s_msValid || s_msTaken;

    // Wrap-around search starting at ptr; only while the output slot can take a request.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        cand      = 0;
        m_msTaken = '0;
        if (free) begin
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                cand = (32'(ptr) + k) % NUM_MASTERS;
                if (!found && m_msValid[cand]) begin
                    found  = 1'b1;
                    winner = PTR_W'(cand);
                end
            end
        end
        if (found) begin
            m_msTaken[winner] = 1'b1;
        end
    end

    assign ptr_next = (32'(winner) == NUM_MASTERS - 1) ? '0 : winner + PTR_W'(1);

    // Output slot: load on grant, drain when accepted with nothing new, else hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_msValid   <= 1'b0;
            s_msWrite   <= 1'b0;
            s_msID      <= '0;
            s_msAddress <= '0;
            s_msData    <= '0;
            ptr         <= '0;
        end else if (found) begin
            s_msValid   <= 1'b1;
            s_msWrite   <= m_msWrite[winner];
            s_msID      <= m_msID[winner*ID_WIDTH +: ID_WIDTH];
            s_msAddress <= m_msAddress[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            s_msData    <= m_msData[winner*DATA_WIDTH +: DATA_WIDTH];
            ptr         <= ptr_next;
        end else if (s_msTaken) begin
            s_msValid   <= 1'b0;
        end
    end

    // Responses are broadcast; masters claim by ID and the claims are merged.
    assign m_smValid = s_smValid;
    assign m_smID    = s_smID;
    assign m_smData  = s_smData;
    assign s_smTaken = |m_smTaken;

`ifdef MEMARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (m_msTaken[i] && grant_count[i*16 +: 16] != 16'hFFFF) begin
                    grant_count[i*16 +: 16] <= grant_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares one MemoryBus slave port between NUM_MASTERS requesters, such as several ray-traversal memory units plus the pixel writer.
- Request channel: round-robin arbitration, with one registered output slot so the slave sees registered signals.
- Response channel: the slave drives smID/smData/smValid, which are broadcast to all masters; each master claims its own response by ID, and the claims are OR-combined back to the slave.
- Sits between the ray units and the memory controller.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DATA_WIDTH, 24, bus data width.
- ADDRESS_WIDTH, 32, bus address width.
- ID_WIDTH, 4, width of msID/smID.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- m_msValid  input  NUM_MASTERS  per-master request valid
- m_msWrite  input  NUM_MASTERS  per-master write flag
- m_msID  input  NUM_MASTERS*ID_WIDTH  per-master ID, packed with master i at slice i
- m_msAddress  input  NUM_MASTERS*ADDRESS_WIDTH  per-master address
- m_msData  input  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_msTaken  output  NUM_MASTERS  one-hot; request i accepted this cycle
- m_smValid  output  1  broadcast response valid
- m_smID  output  ID_WIDTH  broadcast response ID
- m_smData  output  DATA_WIDTH  broadcast response data
- m_smTaken  input  NUM_MASTERS  per-master response claim
- s_msValid  output  1  request valid to slave (registered)
- s_msWrite  output  1  registered write flag
- s_msID  output  ID_WIDTH  registered ID
- s_msAddress  output  ADDRESS_WIDTH  registered address
- s_msData  output  DATA_WIDTH  registered data
- s_msTaken  input  1  slave accepted request
- s_smValid  input  1  slave response valid
- s_smID  input  ID_WIDTH  slave response ID
- s_smData  input  DATA_WIDTH  slave response data
- s_smTaken  output  1  response claimed

Behaviour:
- Reset: s_msValid=0; s_msWrite/s_msID/s_msAddress/s_msData=0; rr pointer=0; m_msTaken=0. Reset mid-transfer drops the slot contents; no request is replayed.
- Slot free condition: free = !s_msValid || s_msTaken.
- Grant (combinational):
  - When free, grant the first i with m_msValid[i]=1, searching i = ptr, ptr+1, …, NUM_MASTERS-1, 0, …, ptr-1 (wrap-around).
  - m_msTaken[winner]=1 in the same cycle; all other bits are 0.
  - No grant when the slot is not free.
- Load: on a grant, the slot registers the winner's write/ID/address/data at the next edge with s_msValid=1. Then ptr <= winner+1, wrapping to 0 after NUM_MASTERS-1.
- Pass-through rate:
  - If s_msTaken=1 and there is no grant, s_msValid <= 0.
  - Simultaneous s_msTaken and grant replace the slot back-to-back, giving 1 request/cycle throughput.
- Latency: master request to s_msValid is 1 cycle.
- Hold: while s_msValid=1 and s_msTaken=0, all s_ms* outputs hold stable.
- No requests: ptr unchanged and the slot drains.
- Response path is purely combinational:
  - m_smValid=s_smValid, m_smID=s_smID, m_smData=s_smData.
  - s_smTaken = |m_smTaken.
  - The arbiter does not check for multiple claimers; unique IDs per master are a system requirement.
- Read and write requests are arbitrated identically.
- Invariant: m_msTaken is at most one-hot in every cycle.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- Defined: adds output port grant_count, NUM_MASTERS*16 bits.
  - Per-master counter increments on each m_msTaken[i].
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single request: master 2 raises valid with address 0x100, write=1, data 0xABCDEF; s_msTaken tied 1.
  -> m_msTaken=4'b0100 in the same cycle; next cycle s_msValid=1, s_msAddress=0x100, s_msData=0xABCDEF; ptr=3.
- Round-robin: all 4 masters valid continuously, s_msTaken=1.
  -> grant order 0,1,2,3,0,1 on consecutive cycles; s_msValid stays 1.
- Backpressure: s_msTaken=0 for 5 cycles while masters 0 and 1 are valid.
  -> m_msTaken=0 throughout; s_ms* stable. When s_msTaken=1, master 1 is granted in that same cycle.
- Wrap: ptr=3 with only master 0 valid.
  -> master 0 granted; ptr becomes 1.
- Response: s_smValid=1, s_smID=2, data 0x123456; m_smTaken=4'b0100.
  -> m_smData=0x123456 on all masters; s_smTaken=1. With m_smTaken=0, s_smTaken=0.
- Reset mid-transfer: assert reset while s_msValid=1 and s_msTaken=0.
  -> next cycle s_msValid=0, ptr=0; the first grant after reset goes to the lowest valid index.
